// File: rtl/sdf_fft_pkg.sv
// Shared constants and sizing helpers for the SDF FFT sample-reordering buffers.
package sdf_fft_pkg;

  localparam int VAR_FIRST  = 0;
  localparam int VAR_SECOND = 1;
  localparam int VAR_FOURTH = 3;

  typedef enum logic [1:0] {
    LEG_FIRST  = 2'd0,
    LEG_SECOND = 2'd1,
    LEG_FOURTH = 2'd3
  } leg_e;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Number of addresses, from 0 upward, that belong to the first read region.
  function automatic int first_region_size(input int variant, input int depth);
    int size;
    case (variant)
      VAR_FIRST:  size = depth / 2;
      VAR_SECOND: size = (3 * depth) / 4;
      default:    size = depth;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/sdf_dbuf_bank.sv
// One DEPTH-entry sample memory: LANES samples written to consecutive addresses
// per cycle, one asynchronous read port (the caller registers the read data).
module sdf_dbuf_bank
  import sdf_fft_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int LANES = 4
) (
  input  logic                          clock,
  input  logic                          wr_en_i,
  input  logic [ptr_width(DEPTH)-1:0]   wr_addr_i,
  input  logic [LANES-1:0][2*WIDTH-1:0] wr_data_i,
  input  logic [ptr_width(DEPTH)-1:0]   rd_addr_i,
  output logic [2*WIDTH-1:0]            rd_data_o
);

  localparam int PW = ptr_width(DEPTH);

  logic [2*WIDTH-1:0] mem_q [DEPTH];

  // Lane i lands at wr_addr_i + i; the pointer width wraps the address modulo DEPTH.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      for (int i = 0; i < LANES; i++) begin
        mem_q[wr_addr_i + PW'(i)] <= wr_data_i[i];
      end
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sdf_dbuf_checker.sv
// Simulation-only protocol checker for sdf_delay_buffer; compiled only when
// SDF_DBUF_ASSERT_EN is defined.
`ifdef SDF_DBUF_ASSERT_EN
module sdf_dbuf_checker
  import sdf_fft_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int VARIANT = 0
) (
  input logic                        clock,
  input logic                        reset,
  input logic                        enable_write,
  input logic                        enable_read_first,
  input logic                        enable_read_last,
  input logic                        rotate,
  input logic                        enable_read,
  input logic [ptr_width(DEPTH)-1:0] rp_i
);

  localparam int FIRST   = first_region_size(VARIANT, DEPTH);
  localparam bit IS_FIFO = (VARIANT == VAR_FOURTH);

  int occ_q;

  // Entries held by the circular FIFO: three in per write, one out per read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occ_q <= 0;
    end else begin
      occ_q <= occ_q + (enable_write ? 3 : 0) - (enable_read ? 1 : 0);
    end
  end

  a_no_x_enables: assert property (@(posedge clock) disable iff (!reset)
    !$isunknown({enable_write, enable_read_first, enable_read_last, rotate, enable_read}));
  a_fifo_overrun: assert property (@(posedge clock) disable iff (!reset)
    !(IS_FIFO && enable_write && (occ_q + 3 - (enable_read ? 1 : 0) > DEPTH)));
  a_fifo_underrun: assert property (@(posedge clock) disable iff (!reset)
    !(IS_FIFO && enable_read && occ_q == 0));
  a_first_region: assert property (@(posedge clock) disable iff (!reset)
    !(!IS_FIFO && enable_read_first && int'(rp_i) >= FIRST));
  a_last_region: assert property (@(posedge clock) disable iff (!reset)
    !(!IS_FIFO && enable_read_last && int'(rp_i) < FIRST));
  a_fifo_pingpong_enables: assert property (@(posedge clock) disable iff (!reset)
    !(IS_FIFO && (enable_read_first || enable_read_last || rotate)));
  a_pingpong_fifo_enable: assert property (@(posedge clock) disable iff (!reset)
    !(!IS_FIFO && enable_read));

endmodule
`endif

// File: rtl/sdf_delay_buffer.sv
// Reordering delay buffer for one butterfly leg of a 4-parallel radix-4 SDF FFT stage.
// VARIANT 0/1: ping-pong banks swapped by rotate; VARIANT 3: circular FIFO. Macro SDF_DBUF_ASSERT_EN adds protocol checks.
module sdf_delay_buffer
  import sdf_fft_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 16,
  parameter int VARIANT = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_write,
  input  logic             enable_read_first,
  input  logic             enable_read_last,
  input  logic             rotate,
  input  logic             enable_read,
  input  logic [WIDTH-1:0] input_real_0,
  input  logic [WIDTH-1:0] input_real_1,
  input  logic [WIDTH-1:0] input_real_2,
  input  logic [WIDTH-1:0] input_real_3,
  input  logic [WIDTH-1:0] input_imag_0,
  input  logic [WIDTH-1:0] input_imag_1,
  input  logic [WIDTH-1:0] input_imag_2,
  input  logic [WIDTH-1:0] input_imag_3,
  output logic [WIDTH-1:0] out_real,
  output logic [WIDTH-1:0] out_imag
);

  localparam int PW = ptr_width(DEPTH);
  localparam int EW = 2 * WIDTH;

  logic [PW-1:0]      wp_q, wp_d, rp_q, rp_d;
  logic               wb_q, wb_d;
  logic               rd_en_s;
  logic [EW-1:0]      rd_data_s;
  logic [WIDTH-1:0]   out_real_q, out_real_d, out_imag_q, out_imag_d;
  logic               unused_s;
  logic [3:0][EW-1:0] lanes_s;

  assign lanes_s = {{input_real_3, input_imag_3}, {input_real_2, input_imag_2},
                    {input_real_1, input_imag_1}, {input_real_0, input_imag_0}};

  if (VARIANT == VAR_FOURTH) begin : g_fifo
    logic [2:0][EW-1:0] fifo_lanes_s;
    assign fifo_lanes_s = lanes_s[3:1];

    sdf_dbuf_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(3)) u_bank (
      .clock     (clock),
      .wr_en_i   (enable_write),
      .wr_addr_i (wp_q),
      .wr_data_i (fifo_lanes_s),
      .rd_addr_i (rp_q),
      .rd_data_o (rd_data_s)
    );

    assign rd_en_s  = enable_read;
    assign unused_s = ^{enable_read_first, enable_read_last, rotate, wb_q, lanes_s[0]};

    // Circular pointers: three entries in per write, one out per read.
    always_comb begin
      wb_d = 1'b0;
      if (enable_write) begin
        wp_d = wp_q + PW'(3);
      end else begin
        wp_d = wp_q;
      end
      if (enable_read) begin
        rp_d = rp_q + PW'(1);
      end else begin
        rp_d = rp_q;
      end
    end
  end else if (VARIANT == VAR_FIRST || VARIANT == VAR_SECOND) begin : g_pingpong
    logic [EW-1:0] rd_a_s, rd_b_s;

    sdf_dbuf_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(4)) u_bank_a (
      .clock     (clock),
      .wr_en_i   (enable_write && !wb_q),
      .wr_addr_i (wp_q),
      .wr_data_i (lanes_s),
      .rd_addr_i (rp_q),
      .rd_data_o (rd_a_s)
    );

    sdf_dbuf_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(4)) u_bank_b (
      .clock     (clock),
      .wr_en_i   (enable_write && wb_q),
      .wr_addr_i (wp_q),
      .wr_data_i (lanes_s),
      .rd_addr_i (rp_q),
      .rd_data_o (rd_b_s)
    );

    // The read bank is always the one not being written.
    assign rd_data_s = wb_q ? rd_a_s : rd_b_s;
    assign rd_en_s   = enable_read_first | enable_read_last;
    assign unused_s  = enable_read;

    // Rotate swaps banks and restarts both pointers after this cycle's access.
    always_comb begin
      if (rotate) begin
        wb_d = ~wb_q;
        wp_d = '0;
        rp_d = '0;
      end else begin
        wb_d = wb_q;
        if (enable_write) begin
          wp_d = wp_q + PW'(4);
        end else begin
          wp_d = wp_q;
        end
        if (rd_en_s) begin
          rp_d = rp_q + PW'(1);
        end else begin
          rp_d = rp_q;
        end
      end
    end
  end else begin : g_bad_variant
    $error("sdf_delay_buffer: unsupported VARIANT %0d", VARIANT);
  end

  // Output holds unless a read pops a new entry.
  always_comb begin
    if (rd_en_s) begin
      out_real_d = rd_data_s[EW-1:WIDTH];
      out_imag_d = rd_data_s[WIDTH-1:0];
    end else begin
      out_real_d = out_real_q;
      out_imag_d = out_imag_q;
    end
  end

  // Pointer, bank-select and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp_q       <= '0;
      rp_q       <= '0;
      wb_q       <= 1'b0;
      out_real_q <= '0;
      out_imag_q <= '0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      wb_q       <= wb_d;
      out_real_q <= out_real_d;
      out_imag_q <= out_imag_d;
    end
  end

  assign out_real = out_real_q;
  assign out_imag = out_imag_q;

`ifdef SDF_DBUF_ASSERT_EN
  sdf_dbuf_checker #(.DEPTH(DEPTH), .VARIANT(VARIANT)) u_checker (
    .clock             (clock),
    .reset             (reset),
    .enable_write      (enable_write),
    .enable_read_first (enable_read_first),
    .enable_read_last  (enable_read_last),
    .rotate            (rotate),
    .enable_read       (enable_read),
    .rp_i              (rp_q)
  );
`else
  // Production build: no protocol checker.
`endif

endmodule

// File: tb/tb_sdf_delay_buffer.sv
// Directed self-checking bench: one instance per VARIANT (0, 1, 3), WIDTH=32, DEPTH=16.
module tb_sdf_delay_buffer;

  localparam int W = 32;

  logic clock = 1'b0;
  logic rst_n;
  logic [W-1:0] in_r0, in_r1, in_r2, in_r3, in_i0, in_i1, in_i2, in_i3;
  logic we0, rf0, rl0, rot0;
  logic we1, rf1, rl1, rot1;
  logic we3, re3, ign3;
  logic [W-1:0] o0_r, o0_i, o1_r, o1_i, o3_r, o3_i;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sdf_delay_buffer #(.WIDTH(W), .DEPTH(16), .VARIANT(0)) u_dut0 (
    .clock(clock), .reset(rst_n), .enable_write(we0), .enable_read_first(rf0),
    .enable_read_last(rl0), .rotate(rot0), .enable_read(1'b0),
    .input_real_0(in_r0), .input_real_1(in_r1), .input_real_2(in_r2), .input_real_3(in_r3),
    .input_imag_0(in_i0), .input_imag_1(in_i1), .input_imag_2(in_i2), .input_imag_3(in_i3),
    .out_real(o0_r), .out_imag(o0_i));

  sdf_delay_buffer #(.WIDTH(W), .DEPTH(16), .VARIANT(1)) u_dut1 (
    .clock(clock), .reset(rst_n), .enable_write(we1), .enable_read_first(rf1),
    .enable_read_last(rl1), .rotate(rot1), .enable_read(1'b0),
    .input_real_0(in_r0), .input_real_1(in_r1), .input_real_2(in_r2), .input_real_3(in_r3),
    .input_imag_0(in_i0), .input_imag_1(in_i1), .input_imag_2(in_i2), .input_imag_3(in_i3),
    .out_real(o1_r), .out_imag(o1_i));

  sdf_delay_buffer #(.WIDTH(W), .DEPTH(16), .VARIANT(3)) u_dut3 (
    .clock(clock), .reset(rst_n), .enable_write(we3), .enable_read_first(ign3),
    .enable_read_last(ign3), .rotate(ign3), .enable_read(re3),
    .input_real_0(in_r0), .input_real_1(in_r1), .input_real_2(in_r2), .input_real_3(in_r3),
    .input_imag_0(in_i0), .input_imag_1(in_i1), .input_imag_2(in_i2), .input_imag_3(in_i3),
    .out_real(o3_r), .out_imag(o3_i));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Lanes carry base..base+3 as real parts, imaginary = real + 100.
  task automatic set_lanes(input int base);
    in_r0 = W'(base);     in_i0 = W'(base + 100);
    in_r1 = W'(base + 1); in_i1 = W'(base + 101);
    in_r2 = W'(base + 2); in_i2 = W'(base + 102);
    in_r3 = W'(base + 3); in_i3 = W'(base + 103);
  endtask

  task automatic test_reset();
    {we0, rf0, rl0, rot0, we1, rf1, rl1, rot1, we3, re3, ign3} = '0;
    set_lanes(0);
    rst_n = 1'b0;
    #12;
    checks++;
    if (o0_r !== 32'd0 || o0_i !== 32'd0) begin
      errors++; $display("FAIL reset_v0: got %0h/%0h expected 0/0", o0_r, o0_i);
    end
    checks++;
    if (o1_r !== 32'd0 || o1_i !== 32'd0) begin
      errors++; $display("FAIL reset_v1: got %0h/%0h expected 0/0", o1_r, o1_i);
    end
    checks++;
    if (o3_r !== 32'd0 || o3_i !== 32'd0) begin
      errors++; $display("FAIL reset_v3: got %0h/%0h expected 0/0", o3_r, o3_i);
    end
    @(negedge clock);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_v0_ordering();
    for (int c = 0; c < 4; c++) begin
      we0 = 1'b1; set_lanes(4 * c); tick();
    end
    we0 = 1'b0; rot0 = 1'b1; tick(); rot0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rf0 = (i < 8); rl0 = (i >= 8); tick();
      checks++;
      if (o0_r !== W'(i) || o0_i !== W'(100 + i)) begin
        errors++;
        $display("FAIL v0_order[%0d]: got %0d/%0d expected %0d/%0d", i, o0_r, o0_i, i, 100 + i);
      end
    end
    rf0 = 1'b0; rl0 = 1'b0;
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (o0_r !== 32'd15 || o0_i !== 32'd115) begin
        errors++; $display("FAIL idle_hold[%0d]: got %0d/%0d expected 15/115", i, o0_r, o0_i);
      end
    end
  endtask

  task automatic test_reset_midstream();
    we0 = 1'b1; set_lanes(900); rf0 = 1'b1; tick();
    we0 = 1'b0; tick();
    rf0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o0_r !== 32'd0 || o0_i !== 32'd0) begin
      errors++; $display("FAIL reset_midstream: got %0d/%0d expected 0/0", o0_r, o0_i);
    end
    @(negedge clock);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      we0 = 1'b1; set_lanes(200 + 4 * c); tick();
    end
    we0 = 1'b0; rot0 = 1'b1; tick(); rot0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rf0 = 1'b1; tick();
      checks++;
      if (o0_r !== W'(200 + i) || o0_i !== W'(300 + i)) begin
        errors++;
        $display("FAIL post_reset_addr[%0d]: got %0d/%0d expected %0d/%0d", i, o0_r, o0_i, 200 + i, 300 + i);
      end
    end
    rf0 = 1'b0;
  endtask

  task automatic test_v0_rotate_read();
    for (int c = 0; c < 3; c++) begin
      we0 = 1'b1; set_lanes(300 + 4 * c); tick();
    end
    we0 = 1'b1; set_lanes(312); rot0 = 1'b1; rf0 = 1'b1; tick();
    we0 = 1'b0; rot0 = 1'b0;
    checks++;
    if (o0_r !== 32'd204 || o0_i !== 32'd304) begin
      errors++; $display("FAIL rotate_read_old: got %0d/%0d expected 204/304", o0_r, o0_i);
    end
    for (int i = 0; i < 16; i++) begin
      rf0 = (i < 8); rl0 = (i >= 8); tick();
      checks++;
      if (o0_r !== W'(300 + i) || o0_i !== W'(400 + i)) begin
        errors++;
        $display("FAIL rotate_read_new[%0d]: got %0d/%0d expected %0d/%0d", i, o0_r, o0_i, 300 + i, 400 + i);
      end
    end
    rf0 = 1'b0; rl0 = 1'b0;
  endtask

  task automatic test_v1_pingpong();
    for (int c = 0; c < 4; c++) begin
      we1 = 1'b1; set_lanes(4 * c); tick();
    end
    we1 = 1'b0; rot1 = 1'b1; tick(); rot1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      we1 = (i % 4 == 0); set_lanes(16 + i);
      rf1 = (i < 12); rl1 = (i >= 12); tick();
      checks++;
      if (o1_r !== W'(i) || o1_i !== W'(100 + i)) begin
        errors++;
        $display("FAIL v1_bank_a[%0d]: got %0d/%0d expected %0d/%0d", i, o1_r, o1_i, i, 100 + i);
      end
    end
    {we1, rf1, rl1} = '0;
    rot1 = 1'b1; tick(); rot1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rf1 = (i < 12); rl1 = (i >= 12); tick();
      checks++;
      if (o1_r !== W'(16 + i) || o1_i !== W'(116 + i)) begin
        errors++;
        $display("FAIL v1_bank_b[%0d]: got %0d/%0d expected %0d/%0d", i, o1_r, o1_i, 16 + i, 116 + i);
      end
    end
    rf1 = 1'b0; rl1 = 1'b0;
  endtask

  // Lane 0 carries 0xDEAD and must never reach the output; lanes 1..3 = 3k+1..3k+3.
  task automatic v3_write(input int k);
    set_lanes(3 * k);
    in_r0 = 32'h0000_DEAD; in_i0 = 32'h0000_DEAD;
    we3 = 1'b1;
  endtask

  task automatic test_v3_fifo();
    for (int c = 0; c < 4; c++) begin
      v3_write(c); tick();
    end
    we3 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      re3 = 1'b1; tick();
      checks++;
      if (o3_r !== W'(i + 1) || o3_i !== W'(i + 101)) begin
        errors++;
        $display("FAIL v3_fifo[%0d]: got %0h/%0h expected %0h/%0h", i, o3_r, o3_i, i + 1, i + 101);
      end
    end
    re3 = 1'b0; ign3 = 1'b1;
    for (int c = 4; c < 6; c++) begin
      v3_write(c); tick();
    end
    we3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      re3 = 1'b1; tick();
      checks++;
      if (o3_r !== W'(13 + i) || o3_i !== W'(113 + i)) begin
        errors++;
        $display("FAIL v3_wrap[%0d]: got %0d/%0d expected %0d/%0d", i, o3_r, o3_i, 13 + i, 113 + i);
      end
    end
    ign3 = 1'b0;
    v3_write(6); re3 = 1'b1; tick();
    we3 = 1'b0;
    checks++;
    if (o3_r !== 32'd3 || o3_i !== 32'd103) begin
      errors++; $display("FAIL v3_read_before_write: got %0d/%0d expected 3/103", o3_r, o3_i);
    end
    tick();
    re3 = 1'b0;
    checks++;
    if (o3_r !== 32'd20 || o3_i !== 32'd120) begin
      errors++; $display("FAIL v3_after_write: got %0d/%0d expected 20/120", o3_r, o3_i);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (o3_r !== 32'd20 || o3_i !== 32'd120) begin
        errors++; $display("FAIL v3_idle_hold[%0d]: got %0d/%0d expected 20/120", i, o3_r, o3_i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_v0_ordering();
    test_idle_hold();
    test_reset_midstream();
    test_v0_rotate_read();
    test_v1_pingpong();
    test_v3_fifo();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
